tagged_round_robin_distributor: RTL and testbench



---
 rtl/tagged_round_robin_distributor.sv | 110 +++++++++++
 tb/tb_tagged_round_robin_distributor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tagged_round_robin_distributor.sv
// Stamps each element of a single stream with a round-robin destination tag, advancing
// in blocks of BLOCK_SIZE kept elements; one registered stage, full throughput.
module tagged_round_robin_distributor #(
  parameter type         data_t          = logic [7:0],
  parameter int unsigned NUM_OUTPUTS     = 4,
  parameter int unsigned TAG_WIDTH       = 2,
  parameter int unsigned BLOCK_SIZE      = 1,
  parameter bit          FILTER_KEEP     = 1'b1,
  parameter bit          RESTART_ON_LAST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  data_t                i_in_data,
  input  logic                 i_in_keep,
  input  logic                 i_in_last,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output data_t                o_out_data,
  output logic [TAG_WIDTH-1:0] o_out_tag,
  output logic                 o_out_keep,
  output logic                 o_out_last,
  output logic                 o_out_valid,
  input  logic                 i_out_ready
);

  localparam int unsigned            CNT_W   = $clog2(BLOCK_SIZE) + 1;
  localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [TAG_WIDTH-1:0]   TAG_MAX = TAG_WIDTH'(NUM_OUTPUTS - 1);

  logic [TAG_WIDTH-1:0] r_tag;
  logic [CNT_W-1:0]     r_cnt;
  data_t                r_data;
  logic [TAG_WIDTH-1:0] r_out_tag;
  logic                 r_keep;
  logic                 r_last;
  logic                 r_valid;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_adv;
  logic                 w_restart;
  logic [TAG_WIDTH-1:0] w_tag_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;

  // The stage can take a new element when empty or when its content leaves this cycle.
  assign w_in_ready = !r_valid || i_out_ready;
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_adv      = w_accept && (i_in_keep || !FILTER_KEEP);
  assign w_restart  = w_accept && i_in_last && RESTART_ON_LAST;

  // Next distribution state; a restarting last overrides the block advance.
  always_comb begin
    w_tag_nxt = r_tag;
    w_cnt_nxt = r_cnt;
    if (w_restart) begin
      w_tag_nxt = '0;
      w_cnt_nxt = '0;
    end else if (w_adv) begin
      if (r_cnt == CNT_MAX) begin
        w_cnt_nxt = '0;
        w_tag_nxt = (r_tag == TAG_MAX) ? '0 : r_tag + TAG_WIDTH'(1);
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else begin
      w_tag_nxt = r_tag;
      w_cnt_nxt = r_cnt;
    end
  end

  // Distribution counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
      r_cnt <= '0;
    end else begin
      r_tag <= w_tag_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Output register: load on accept (replacing a draining element), clear valid on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_out_tag <= '0;
      r_keep    <= 1'b0;
      r_last    <= 1'b0;
      r_valid   <= 1'b0;
    end else if (w_accept) begin
      r_data    <= i_in_data;
      r_out_tag <= r_tag;
      r_keep    <= i_in_keep;
      r_last    <= i_in_last;
      r_valid   <= 1'b1;
    end else if (i_out_ready) begin
      r_valid   <= 1'b0;
    end else begin
      r_valid   <= r_valid;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_data  = r_data;
  assign o_out_tag   = r_out_tag;
  assign o_out_keep  = r_keep;
  assign o_out_last  = r_last;
  assign o_out_valid = r_valid;

endmodule

// File: tb/tb_tagged_round_robin_distributor.sv
// Drives four differently parameterised distributors from one stream and checks
// tags against hand-computed tables, then backpressure and mid-stream reset.
module tb_tagged_round_robin_distributor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_keep = 1'b0;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;

  logic [7:0] a_data, b_data, c_data, d_data;
  logic [1:0] a_tag, c_tag, d_tag;
  logic [0:0] b_tag;
  logic       a_keep, b_keep, c_keep, d_keep;
  logic       a_last, b_last, c_last, d_last;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic       a_rdy, b_rdy, c_rdy, d_rdy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tagged_round_robin_distributor #(.NUM_OUTPUTS(3), .TAG_WIDTH(2), .BLOCK_SIZE(1),
    .FILTER_KEEP(1'b1), .RESTART_ON_LAST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .i_in_data(in_data), .i_in_keep(in_keep), .i_in_last(in_last),
    .i_in_valid(in_valid), .o_in_ready(a_rdy), .o_out_data(a_data), .o_out_tag(a_tag),
    .o_out_keep(a_keep), .o_out_last(a_last), .o_out_valid(a_valid), .i_out_ready(out_ready));

  tagged_round_robin_distributor #(.NUM_OUTPUTS(2), .TAG_WIDTH(1), .BLOCK_SIZE(3),
    .FILTER_KEEP(1'b1), .RESTART_ON_LAST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .i_in_data(in_data), .i_in_keep(in_keep), .i_in_last(in_last),
    .i_in_valid(in_valid), .o_in_ready(b_rdy), .o_out_data(b_data), .o_out_tag(b_tag),
    .o_out_keep(b_keep), .o_out_last(b_last), .o_out_valid(b_valid), .i_out_ready(out_ready));

  tagged_round_robin_distributor #(.NUM_OUTPUTS(4), .TAG_WIDTH(2), .BLOCK_SIZE(1),
    .FILTER_KEEP(1'b0), .RESTART_ON_LAST(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .i_in_data(in_data), .i_in_keep(in_keep), .i_in_last(in_last),
    .i_in_valid(in_valid), .o_in_ready(c_rdy), .o_out_data(c_data), .o_out_tag(c_tag),
    .o_out_keep(c_keep), .o_out_last(c_last), .o_out_valid(c_valid), .i_out_ready(out_ready));

  tagged_round_robin_distributor #(.NUM_OUTPUTS(4), .TAG_WIDTH(2), .BLOCK_SIZE(1),
    .FILTER_KEEP(1'b1), .RESTART_ON_LAST(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .i_in_data(in_data), .i_in_keep(in_keep), .i_in_last(in_last),
    .i_in_valid(in_valid), .o_in_ready(d_rdy), .o_out_data(d_data), .o_out_tag(d_tag),
    .o_out_keep(d_keep), .o_out_last(d_last), .o_out_valid(d_valid), .i_out_ready(out_ready));

  typedef struct {
    logic [7:0] data;
    logic       keep;
    logic       last;
    logic [1:0] ta;
    logic [1:0] tb;
    logic [1:0] tc;
    logic [1:0] td;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [7:0] dat, input logic [1:0] tag,
                         input logic kp, input logic lst, input logic vld, input vec_t v,
                         input logic [1:0] etag);
    chk({nm, ".valid"}, {31'd0, vld}, 32'd1);
    chk({nm, ".data"},  {24'd0, dat}, {24'd0, v.data});
    chk({nm, ".tag"},   {30'd0, tag}, {30'd0, etag});
    chk({nm, ".keep"},  {31'd0, kp},  {31'd0, v.keep});
    chk({nm, ".last"},  {31'd0, lst}, {31'd0, v.last});
  endtask

  initial begin
    // 7 kept elements then a last: round-robin and blocking
    vecs[0]  = '{8'h10, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[1]  = '{8'h11, 1'b1, 1'b0, 2'd1, 2'd0, 2'd1, 2'd1};
    vecs[2]  = '{8'h12, 1'b1, 1'b0, 2'd2, 2'd0, 2'd2, 2'd2};
    vecs[3]  = '{8'h13, 1'b1, 1'b0, 2'd0, 2'd1, 2'd3, 2'd3};
    vecs[4]  = '{8'h14, 1'b1, 1'b0, 2'd1, 2'd1, 2'd0, 2'd0};
    vecs[5]  = '{8'h15, 1'b1, 1'b0, 2'd2, 2'd1, 2'd1, 2'd1};
    vecs[6]  = '{8'h16, 1'b1, 1'b0, 2'd0, 2'd0, 2'd2, 2'd2};
    vecs[7]  = '{8'h17, 1'b1, 1'b1, 2'd1, 2'd0, 2'd3, 2'd3};
    // keep pattern 1,0,1,1 ending with last
    vecs[8]  = '{8'h20, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[9]  = '{8'h21, 1'b0, 1'b0, 2'd1, 2'd0, 2'd1, 2'd1};
    vecs[10] = '{8'h22, 1'b1, 1'b0, 2'd1, 2'd0, 2'd2, 2'd1};
    vecs[11] = '{8'h23, 1'b1, 1'b1, 2'd2, 2'd0, 2'd3, 2'd2};
    // two streams of two
    vecs[12] = '{8'h30, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[13] = '{8'h31, 1'b1, 1'b1, 2'd1, 2'd0, 2'd1, 2'd1};
    vecs[14] = '{8'h32, 1'b1, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0};
    vecs[15] = '{8'h33, 1'b1, 1'b1, 2'd1, 2'd0, 2'd3, 2'd1};
    // keep=0 last still forwarded and restarts
    vecs[16] = '{8'h40, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[17] = '{8'h41, 1'b0, 1'b1, 2'd1, 2'd0, 2'd1, 2'd1};

    #7;
    chk("rst.valid_a", {31'd0, a_valid}, 32'd0);
    chk("rst.valid_d", {31'd0, d_valid}, 32'd0);
    chk("rst.tag_d",   {30'd0, d_tag},   32'd0);
    chk("rst.keep_d",  {31'd0, d_keep},  32'd0);
    chk("rst.last_d",  {31'd0, d_last},  32'd0);
    chk("rst.ready_d", {31'd0, d_rdy},   32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      in_keep  = vecs[i].keep;
      in_last  = vecs[i].last;
      @(posedge clk); #1;
      chk_out("a", a_data, a_tag, a_keep, a_last, a_valid, vecs[i], vecs[i].ta);
      chk_out("b", b_data, {1'b0, b_tag}, b_keep, b_last, b_valid, vecs[i], vecs[i].tb);
      chk_out("c", c_data, c_tag, c_keep, c_last, c_valid, vecs[i], vecs[i].tc);
      chk_out("d", d_data, d_tag, d_keep, d_last, d_valid, vecs[i], vecs[i].td);
      chk("tbl.ready", {31'd0, d_rdy}, 32'd1);
    end

    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain.valid_a", {31'd0, a_valid}, 32'd0);
    chk("drain.valid_c", {31'd0, c_valid}, 32'd0);

    // backpressure: first element accepted, then stalled for 5 cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA0;
    in_keep   = 1'b1;
    in_last   = 1'b0;
    @(posedge clk); #1;
    chk("bp.first_data", {24'd0, d_data}, 32'hA0);
    chk("bp.first_tag",  {30'd0, d_tag},  32'd0);
    in_data = 8'hA1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp.valid", {31'd0, d_valid}, 32'd1);
      chk("bp.data",  {24'd0, d_data},  32'hA0);
      chk("bp.tag_d", {30'd0, d_tag},   32'd0);
      chk("bp.tag_a", {30'd0, a_tag},   32'd0);
      chk("bp.ready", {31'd0, d_rdy},   32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel.valid", {31'd0, d_valid}, 32'd1);
    chk("rel.data",  {24'd0, d_data},  32'hA1);
    chk("rel.tag_d", {30'd0, d_tag},   32'd1);
    chk("rel.tag_a", {30'd0, a_tag},   32'd1);

    // hold A1 with tag_q at 2, then reset asynchronously mid-cycle
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("hold.valid", {31'd0, d_valid}, 32'd1);
    chk("hold.data",  {24'd0, d_data},  32'hA1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid_d", {31'd0, d_valid}, 32'd0);
    chk("arst.valid_a", {31'd0, a_valid}, 32'd0);
    chk("arst.tag_d",   {30'd0, d_tag},   32'd0);
    chk("arst.ready_d", {31'd0, d_rdy},   32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hB0;
    in_keep   = 1'b1;
    @(posedge clk); #1;
    chk("post.data",  {24'd0, d_data},  32'hB0);
    chk("post.tag_d", {30'd0, d_tag},   32'd0);
    chk("post.tag_a", {30'd0, a_tag},   32'd0);
    chk("post.tag_c", {30'd0, c_tag},   32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post.drain", {31'd0, d_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
